// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind a MAC array: bias plus tile_num dot products, one result per pixel.
// Optional PSUM_SAT_EN saturates each accumulation step instead of wrapping.
module psum_accumulator #(
  parameter int IN_DW  = 20,
  parameter int ACC_DW = 32,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_tile_num,
  input  logic [ACC_DW-1:0] i_bias,
  input  logic              i_vld,
  input  logic [IN_DW-1:0]  i_dat,
  output logic              o_busy,
  output logic              o_vld,
  output logic [ACC_DW-1:0] o_dat,
  output logic              o_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e            state_q, state_d;
  logic [ACC_DW-1:0] acc_q, acc_d, dat_q, dat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tile_q, tile_d;
  logic              vld_q, vld_d, ovf_q, ovf_d;

  logic [ACC_DW-1:0] ext, sum_raw, sum;
  logic              step_ovf;

  assign ext      = ACC_DW'($signed(i_dat));
  assign sum_raw  = acc_q + ext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign step_ovf = (acc_q[ACC_DW-1] == ext[ACC_DW-1]) &&
                    (sum_raw[ACC_DW-1] != acc_q[ACC_DW-1]);

`ifdef PSUM_SAT_EN
  localparam logic [ACC_DW-1:0] SAT_MAX = {1'b0, {(ACC_DW-1){1'b1}}};
  localparam logic [ACC_DW-1:0] SAT_MIN = {1'b1, {(ACC_DW-1){1'b0}}};
  assign sum = step_ovf ? (acc_q[ACC_DW-1] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
  assign sum = sum_raw;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          tile_d  = (i_tile_num == '0) ? CNT_W'(1) : i_tile_num;
          acc_d   = i_bias;
          cnt_d   = '0;
          state_d = ACC;
        end else if (i_vld) begin
          ovf_d = 1'b1;
        end
      end
      ACC: begin
        if (i_vld) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (step_ovf) ovf_d = 1'b1;
          if (cnt_q == tile_q - CNT_W'(1)) begin
            dat_d   = sum;
            vld_d   = 1'b1;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (i_vld) ovf_d = 1'b1;
        // Accepting start here gives back-to-back pixels with no bubble.
        if (i_start) begin
          tile_d  = (i_tile_num == '0) ? CNT_W'(1) : i_tile_num;
          acc_d   = i_bias;
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tile_q  <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_vld  = vld_q;
  assign o_dat  = dat_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator; expected sums are queued at the last beat and checked on o_vld.
module tb_psum_accumulator;
  localparam int IN_DW  = 20;
  localparam int ACC_DW = 32;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [CNT_W-1:0]  i_tile_num;
  logic [ACC_DW-1:0] i_bias;
  logic              i_vld;
  logic [IN_DW-1:0]  i_dat;
  logic              o_busy, o_vld, o_ovf;
  logic [ACC_DW-1:0] o_dat;

  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int vld_mark;
  logic [ACC_DW-1:0] exp_q[$];

  psum_accumulator #(.IN_DW(IN_DW), .ACC_DW(ACC_DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_tile_num(i_tile_num),
    .i_bias(i_bias), .i_vld(i_vld), .i_dat(i_dat),
    .o_busy(o_busy), .o_vld(o_vld), .o_dat(o_dat), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_DW-1:0] obs, input logic [ACC_DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    logic [31:0] t;
    t = v;
    i_vld = 1'b1;
    i_dat = t[IN_DW-1:0];
  endtask

  task automatic start(input int tiles, input int bias);
    logic [31:0] t;
    t = tiles;
    i_start    = 1'b1;
    i_tile_num = t[CNT_W-1:0];
    i_bias     = bias;
  endtask

  // Scoreboard: each o_vld must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && o_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) check("unexpected_vld", o_dat, 'x);
      else check("o_dat", o_dat, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_tile_num = '0; i_bias = '0; i_vld = 1'b0; i_dat = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_vld",  32'(o_vld), 0);
    check("rst_dat",  o_dat, 0);
    check("rst_ovf",  32'(o_ovf), 0);

    // Basic sum: 100 + 5 - 7 + 20
    start(3, 100); tick(); i_start = 1'b0;
    beat(5); tick();
    beat(-7); tick();
    beat(20); exp_q.push_back(118); tick();
    i_vld = 1'b0;
    check("basic_vld", 32'(o_vld), 1);
    check("basic_busy_out", 32'(o_busy), 1);
    tick();
    check("basic_busy_fall", 32'(o_busy), 0);
    check("basic_hold", o_dat, 118);

    // Gapped input
    vld_mark = vld_cnt;
    start(2, 0); tick(); i_start = 1'b0;
    beat(-3); tick(); i_vld = 1'b0;
    repeat (4) begin
      tick();
      check("gap_busy", 32'(o_busy), 1);
    end
    beat(-4); exp_q.push_back(-7); tick(); i_vld = 1'b0;
    tick(); tick();
    check("gap_single_pulse", vld_cnt - vld_mark, 1);
    check("gap_ovf", 32'(o_ovf), 0);

    // Back-to-back: A = 7 + 3, start B during A's OUT cycle
    start(1, 7); tick(); i_start = 1'b0;
    beat(3); exp_q.push_back(10); tick(); i_vld = 1'b0;
    check("b2b_a_vld", 32'(o_vld), 1);
    start(1, 1); tick(); i_start = 1'b0;
    check("b2b_no_bubble", 32'(o_busy), 1);
    check("b2b_a_hold", o_dat, 10);
    beat(2); exp_q.push_back(3); tick(); i_vld = 1'b0;
    check("b2b_b_vld", 32'(o_vld), 1);
    tick();

    // tile_num 0 acts as one tile; stray beat afterwards flags ovf
    start(0, -5); tick(); i_start = 1'b0;
    beat(5); exp_q.push_back(0); tick(); i_vld = 1'b0;
    tick();
    check("edge_ovf_clear", 32'(o_ovf), 0);
    vld_mark = vld_cnt;
    beat(9); tick(); i_vld = 1'b0;
    check("stray_ovf", 32'(o_ovf), 1);
    check("stray_busy", 32'(o_busy), 0);
    tick(); tick();
    check("stray_no_vld", vld_cnt - vld_mark, 0);

    // Overflow
    rst = 1'b1; tick(); rst = 1'b0;
    check("ovf_rst_clear", 32'(o_ovf), 0);
    start(1, 32'h7FFF_FFF0); tick(); i_start = 1'b0;
`ifdef PSUM_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h8000_0010);
`endif
    beat(32'h20); tick(); i_vld = 1'b0;
    check("ovf_flag", 32'(o_ovf), 1);
    tick();

    // Reset mid-accumulation
    rst = 1'b1; tick(); rst = 1'b0;
    vld_mark = vld_cnt;
    start(4, 0); tick(); i_start = 1'b0;
    beat(1); tick();
    beat(2); tick();
    i_vld = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_dat", o_dat, 0);
    check("midrst_ovf", 32'(o_ovf), 0);
    beat(3); tick();
    beat(4); tick(); i_vld = 1'b0;
    tick();
    check("midrst_no_vld", vld_cnt - vld_mark, 0);
    check("midrst_dat_after", o_dat, 0);
    check("midrst_stray_ovf", 32'(o_ovf), 1);
    start(2, 10); tick(); i_start = 1'b0;
    beat(1); tick();
    beat(2); exp_q.push_back(13); tick(); i_vld = 1'b0;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
